mult_share_arbiter: RTL and testbench
=====================================

Name: mult_share_arbiter

Overview:
- Shares one pipelined signed 18x18 multiplier between NUM_REQ independent requesters, e.g. audio voices, sprite scaler and CPU MMIO.
- Arbitrates round-robin, launches one operation at a time through the multiplier's input_rdy/busy handshake, captures the 36-bit product and returns it to the owning requester with a one-cycle valid pulse.
- Sits between the requester logic and the multiplier instance in the SoC.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- BUSY_WAIT, 4, max cycles after start to see mul_busy rise before flagging an error.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  request pending; hold it and the operands stable until req_ready.
- req_a  in  18*NUM_REQ  signed operand A; requester i uses bits [18i+17:18i].
- req_b  in  18*NUM_REQ  signed operand B, same packing as req_a.
- req_ready  out  NUM_REQ  one-hot one-cycle pulse: operands of that requester accepted.
- resp_valid  out  NUM_REQ  one-hot one-cycle pulse: resp_p belongs to that requester.
- resp_p  out  36  signed product, held until the next resp_valid.
- mul_a  out  18  operand A to the multiplier.
- mul_b  out  18  operand B to the multiplier.
- mul_start  out  1  drives multiplier input_rdy; one-cycle pulse.
- mul_busy  in  1  multiplier busy.
- mul_p  in  36  multiplier product; valid on the first cycle busy is low after being high.
- err  out  1  sticky: busy never rose within BUSY_WAIT; cleared only by reset.

Behaviour:
- All outputs are registered.
- Reset values: req_ready=0, resp_valid=0, resp_p=0, mul_a=0, mul_b=0, mul_start=0, err=0, rr_ptr=0, state=DRAIN.
- DRAIN: wait until mul_busy=0 so any in-flight result is discarded, then go to IDLE. On reset mid-operation, the old product is never delivered.
- IDLE: if any req_valid, choose the winner by round-robin, searching from rr_ptr upward with wrap.
  - Latch the winner's a/b into mul_a/mul_b and record it as owner.
  - Next cycle: req_ready[owner]=1 and mul_start=1 for exactly one cycle, then go to WAIT_BUSY.
- Round-robin pointer: rr_ptr = owner+1 mod NUM_REQ, updated at grant. With every request asserted continuously, grants rotate 0,1,2,3,0,...
- WAIT_BUSY: count cycles from the start pulse.
  - If mul_busy=1, go to WAIT_DONE.
  - If the count reaches BUSY_WAIT with busy still 0, set err=1, capture mul_p and go to RESP.
- WAIT_DONE: on the first cycle mul_busy=0, capture mul_p into resp_p and go to RESP.
- RESP: resp_valid[owner]=1 for one cycle, then IDLE. A new arbitration may be evaluated in that same IDLE entry cycle.
- Latency: req_valid high in IDLE at cycle 0 gives req_ready and mul_start at cycle 1, and resp_valid at (cycle busy falls)+2.
  - With the 16-cycle-busy multiplier: resp_valid at cycle 19.
- One operation in flight at a time; no queueing inside the block.
- Requester rules:
  - A requester may drop req_valid before its grant with no effect.
  - Operand changes after req_ready have no effect on the running operation.
  - A requester may re-assert req_valid in the cycle after its req_ready; it becomes eligible again, but only after the others by round-robin.
- Simultaneous events:
  - req_valid arriving in DRAIN/WAIT/RESP is held off, never lost, as long as it stays asserted.
  - resp_valid for requester i and req_ready for requester j are never high in the same cycle.
- Arithmetic: no processing of the product. resp_p = mul_p bit-exact, signed 36-bit two's complement. Operands are passed through unmodified.
- Invalid states decode to DRAIN.

Test Plan:
- Single request: requester 0 with a=50, b=-100. Expect req_ready[0] at cycle 1, one mul_start pulse, and resp_valid[0] with resp_p=-5000 (36'hFFFFFEC78). No other ready/valid bits pulse.
- Fairness: all 4 requesters valid continuously, each with distinct operands (a=i+1, b=1000). Grants in order 0,1,2,3,0. Each resp_valid matches the owner's product (1000, 2000, 3000, 4000). Only one mul_start per operation.
- Extremes: a=-131072, b=-131072 gives resp_p=17179869184 (36'h400000000). a=131071, b=-131072 gives -17179738112.
- Reset mid-op: assert reset while in WAIT_DONE with mul_busy high. All outputs read 0 immediately (asynchronous). After release the block stays in DRAIN until busy falls, and no resp_valid appears for the killed operation. A new request then completes normally.
- Stuck multiplier: hold mul_busy=0 after mul_start. err sets 4 cycles later, resp_valid still pulses for the owner, and err stays 1 through later good operations.
- Withdrawn request: requester 2 asserts req_valid during another's WAIT_DONE, then drops it before grant. Expect no req_ready[2] and no resp_valid[2].

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Purpose: round-robin sharing of one pipelined signed 18x18 multiplier among NUM_REQ requesters.
// Latency: req_ready/mul_start one cycle after a request is seen idle; resp_valid two cycles after mul_busy falls.
// Backpressure: one operation in flight; other requesters are held off (never dropped) while they keep req_valid high.
module mult_share_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int BUSY_WAIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [18*NUM_REQ-1:0]   req_a,
  input  logic [18*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      resp_valid,
  output logic [35:0]             resp_p,
  output logic [17:0]             mul_a,
  output logic [17:0]             mul_b,
  output logic                    mul_start,
  input  logic                    mul_busy,
  input  logic [35:0]             mul_p,
  output logic                    err
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(BUSY_WAIT + 1);

  typedef enum logic [2:0] {
    DRAIN     = 3'd0,
    IDLE      = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  state_t               state_q;
  logic [PW-1:0]        rr_ptr_q;
  logic [PW-1:0]        owner_q;
  logic [CW-1:0]        cnt_q;
  logic [NUM_REQ-1:0]   req_ready_q;
  logic [NUM_REQ-1:0]   resp_valid_q;
  logic [35:0]          resp_p_q;
  logic [17:0]          mul_a_q;
  logic [17:0]          mul_b_q;
  logic                 mul_start_q;
  logic                 err_q;

  logic [17:0]          a_arr [NUM_REQ];
  logic [17:0]          b_arr [NUM_REQ];
  logic                 grant_vld_d;
  logic [PW-1:0]        grant_idx_d;
  logic [PW-1:0]        rr_d;
  logic                 hi_found;
  logic                 lo_found;
  logic [PW-1:0]        hi_idx;
  logic [PW-1:0]        lo_idx;

  // Unpack the per-requester operand slices.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = req_a[i*18 +: 18];
      b_arr[i] = req_b[i*18 +: 18];
    end
  end

  // Round-robin pick: lowest valid index at or above rr_ptr, else lowest valid index below it (wrap).
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_idx   = '0;
    lo_idx   = '0;
    // Scan downward so the last hit in each half is its lowest index.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        if (i >= int'(rr_ptr_q)) begin
          hi_found = 1'b1;
          hi_idx   = PW'(i);
        end else begin
          lo_found = 1'b1;
          lo_idx   = PW'(i);
        end
      end
    end
    grant_vld_d = hi_found | lo_found;
    grant_idx_d = hi_found ? hi_idx : lo_idx;
    if (grant_idx_d == PW'(NUM_REQ - 1)) begin
      rr_d = '0;
    end else begin
      rr_d = grant_idx_d + PW'(1);
    end
  end

  // Control FSM with registered outputs; pulse outputs default low every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= DRAIN;
      rr_ptr_q     <= '0;
      owner_q      <= '0;
      cnt_q        <= '0;
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      resp_p_q     <= '0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      mul_start_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      req_ready_q  <= '0;
      resp_valid_q <= '0;
      mul_start_q  <= 1'b0;
      case (state_q)
        // A result still in the multiplier after reset belongs to nobody; let it drain out.
        DRAIN: begin
          if (!mul_busy) state_q <= IDLE;
        end
        IDLE: begin
          if (grant_vld_d) begin
            owner_q     <= grant_idx_d;
            rr_ptr_q    <= rr_d;
            mul_a_q     <= a_arr[grant_idx_d];
            mul_b_q     <= b_arr[grant_idx_d];
            req_ready_q <= NUM_REQ'(1) << grant_idx_d;
            mul_start_q <= 1'b1;
            cnt_q       <= CW'(1);
            state_q     <= WAIT_BUSY;
          end
        end
        // The start cycle counts as 1; a multiplier that never raises busy is flagged but still answered.
        WAIT_BUSY: begin
          if (mul_busy) begin
            state_q <= WAIT_DONE;
          end else if (cnt_q >= CW'(BUSY_WAIT)) begin
            err_q    <= 1'b1;
            resp_p_q <= mul_p;
            state_q  <= RESP;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        WAIT_DONE: begin
          if (!mul_busy) begin
            resp_p_q <= mul_p;
            state_q  <= RESP;
          end
        end
        // resp_valid lands in the IDLE entry cycle, so it can never coincide with a req_ready pulse.
        RESP: begin
          resp_valid_q <= NUM_REQ'(1) << owner_q;
          state_q      <= IDLE;
        end
        default: state_q <= DRAIN;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_p     = resp_p_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign mul_start  = mul_start_q;
  assign err        = err_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: table-driven single operations, hand sequences for fairness,
// withdrawal, stuck multiplier and reset mid-operation, then random traffic against a
// transaction-level round-robin model.
module tb_mult_share_arbiter;
  localparam int N  = 4;
  localparam int BW = 4;
  localparam logic [35:0] STUCK_P = 36'h987654321;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [18*N-1:0]   req_a;
  logic [18*N-1:0]   req_b;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      resp_valid;
  logic [35:0]       resp_p;
  logic [17:0]       mul_a;
  logic [17:0]       mul_b;
  logic              mul_start;
  logic              mul_busy;
  logic [35:0]       mul_p;
  logic              err;

  always #5 clk = ~clk;

  mult_share_arbiter #(.NUM_REQ(N), .BUSY_WAIT(BW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_p(resp_p),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start),
    .mul_busy(mul_busy), .mul_p(mul_p), .err(err)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;

  // multiplier model
  int busy_cnt = 0;
  int lat_lo = 15;
  int lat_hi = 15;
  bit stuck = 1'b0;
  logic [35:0] prod;
  int fall_cyc = -1000;

  // observation stats
  int rdy_cnt, resp_cnt, start_cnt, last_rdy_cyc, last_resp_cyc;
  int err_cyc = -1;
  logic [N-1:0] rdy_or, resp_or, last_resp;
  logic [35:0] last_resp_p;

  // transaction-level reference model for random traffic
  bit model_on = 1'b0;
  bit m_free = 1'b0;
  int m_ptr = 0;
  int m_owner = 0;
  int m_fall = -1;
  logic [35:0] m_exp_p;

  typedef struct {
    int          r;
    logic [17:0] a;
    logic [17:0] b;
    logic [35:0] p;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input bit v, input logic [17:0] a, input logic [17:0] b);
    req_valid[i]      = v;
    req_a[i*18 +: 18] = a;
    req_b[i*18 +: 18] = b;
  endtask

  task automatic clear_stats();
    rdy_cnt = 0; resp_cnt = 0; start_cnt = 0;
    last_rdy_cyc = -1000; last_resp_cyc = -1000;
    rdy_or = '0; resp_or = '0; last_resp = '0; last_resp_p = '0;
  endtask

  // One clock: multiplier behaviour, statistics and (optionally) the reference model.
  task automatic step();
    logic          start_seen, was_busy;
    logic [17:0]   sa, sb;
    logic [N-1:0]  pv, exp_rdy, exp_resp;
    logic [18*N-1:0] pa, pb;
    bit            pf;
    int            w;
    start_seen = mul_start; sa = mul_a; sb = mul_b;
    pv = req_valid; pa = req_a; pb = req_b; pf = m_free;
    @(posedge clk);
    #1;
    cyc++;
    if (stuck) begin
      mul_busy = 1'b0;
      mul_p    = STUCK_P;
    end else begin
      was_busy = mul_busy;
      if (busy_cnt > 0) busy_cnt--;
      if (start_seen) begin
        busy_cnt = $urandom_range(lat_hi, lat_lo);
        prod     = $signed(sa) * $signed(sb);
      end
      mul_busy = (busy_cnt > 0);
      if (was_busy && !mul_busy) begin
        mul_p    = prod;
        fall_cyc = cyc;
      end else begin
        mul_p = 36'({$urandom(), $urandom()});
      end
    end
    if (req_ready != '0) begin rdy_cnt++; last_rdy_cyc = cyc; end
    rdy_or |= req_ready;
    if (resp_valid != '0) begin
      resp_cnt++; last_resp_cyc = cyc; last_resp = resp_valid; last_resp_p = resp_p;
    end
    resp_or |= resp_valid;
    if (mul_start) start_cnt++;
    if (err && err_cyc < 0) err_cyc = cyc;
    if (model_on) begin
      exp_rdy = '0; exp_resp = '0;
      if (pf && pv != '0) begin
        w = -1;
        for (int k = 0; k < N; k++) if (w < 0 && pv[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        exp_rdy[w] = 1'b1;
        m_owner = w; m_ptr = (w + 1) % N; m_free = 1'b0; m_fall = -1;
        m_exp_p = $signed(pa[w*18 +: 18]) * $signed(pb[w*18 +: 18]);
      end
      if (!m_free && m_fall < 0 && fall_cyc == cyc) m_fall = cyc;
      if (!m_free && m_fall >= 0 && cyc == m_fall + 2) exp_resp[m_owner] = 1'b1;
      check("rr_ready", req_ready, exp_rdy);
      check("rr_start", mul_start, exp_rdy != '0);
      check("rr_resp", resp_valid, exp_resp);
      if (exp_resp != '0) begin
        check("rr_prod", resp_p, m_exp_p);
        m_free = 1'b1;
      end
    end
  endtask

  // Single operation from an idle block; checks latencies, owner, product and pulse counts.
  task automatic do_op(input int r, input logic [17:0] a, input logic [17:0] b,
                       input logic [35:0] exp_p, input int exp_lat, input string tag,
                       output int t0);
    clear_stats();
    t0 = cyc;
    set_req(r, 1'b1, a, b);
    for (int k = 0; k < 60 && resp_cnt == 0; k++) begin
      step();
      if (req_ready[r]) req_valid[r] = 1'b0;
    end
    req_valid[r] = 1'b0;
    check({tag, "_rdy_lat"}, last_rdy_cyc - t0, 1);
    check({tag, "_resp_lat"}, last_resp_cyc - t0, exp_lat);
    check({tag, "_owner"}, last_resp, N'(1) << r);
    check({tag, "_prod"}, last_resp_p, exp_p);
    check({tag, "_pulses"}, rdy_cnt * 100 + start_cnt * 10 + resp_cnt, 111);
    check({tag, "_others"}, {rdy_or, resp_or}, {N'(1) << r, N'(1) << r});
  endtask

  vec_t tbl [8];

  initial begin
    int t0;
    // a, b, product as 18/36-bit two's complement
    tbl[0] = '{0, 18'h00032, 18'h3FF9C, 36'hFFFFFEC78};  //  50 * -100 = -5000
    tbl[1] = '{1, 18'h20000, 18'h20000, 36'h400000000};  // -131072 * -131072
    tbl[2] = '{2, 18'h1FFFF, 18'h20000, 36'hC00020000};  //  131071 * -131072
    tbl[3] = '{3, 18'h1FFFF, 18'h1FFFF, 36'h3FFFC0001};  //  131071 * 131071
    tbl[4] = '{0, 18'h00000, 18'h12345, 36'h000000000};  //  0 * x
    tbl[5] = '{1, 18'h3FFFF, 18'h3FFFF, 36'h000000001};  //  -1 * -1
    tbl[6] = '{2, 18'h004D2, 18'h3FFFF, 36'hFFFFFFB2E};  //  1234 * -1
    tbl[7] = '{3, 18'h0012C, 18'h000C8, 36'h00000EA60};  //  300 * 200

    reset = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0;
    mul_busy = 1'b0; mul_p = '0;
    clear_stats();
    step(); step();
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_p", resp_p, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_mul_start", mul_start, 0);
    check("rst_err", err, 0);
    reset = 1'b0;
    step(); step(); step();

    // Fairness: everybody requesting continuously, re-asserting the cycle after its grant.
    begin : fairness
      int gorder [5];
      int rorder [5];
      logic [35:0] rp [5];
      int ng, nr, idx;
      logic [N-1:0] reassert;
      ng = 0; nr = 0; idx = 0; reassert = '0;
      clear_stats();
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 18'(i + 1), 18'd1000);
      for (int k = 0; k < 300 && nr < 5; k++) begin
        step();
        for (int i = 0; i < N; i++) if (reassert[i]) begin req_valid[i] = 1'b1; reassert[i] = 1'b0; end
        if (req_ready != '0) begin
          for (int i = 0; i < N; i++) if (req_ready[i]) idx = i;
          if (ng < 5) gorder[ng] = idx;
          ng++;
          req_valid[idx] = 1'b0;
          if (ng < 5) reassert[idx] = 1'b1;
          else begin req_valid = '0; reassert = '0; end
        end
        if (resp_valid != '0) begin
          for (int i = 0; i < N; i++) if (resp_valid[i]) rorder[nr] = i;
          rp[nr] = resp_p;
          nr++;
        end
      end
      check("fair_ngrants", ng, 5);
      check("fair_nresp", nr, 5);
      check("fair_starts", start_cnt, 5);
      for (int j = 0; j < 5; j++) begin
        if (j < ng) check("fair_grant", gorder[j], j % N);
        if (j < nr) begin
          check("fair_resp_owner", rorder[j], j % N);
          check("fair_resp_p", rp[j], 36'(((j % N) + 1) * 1000));
        end
      end
    end

    // Table of single operations, each launched in the IDLE cycle of the previous response.
    for (int v = 0; v < 8; v++) do_op(tbl[v].r, tbl[v].a, tbl[v].b, tbl[v].p, 19, $sformatf("vec%0d", v), t0);

    // Withdrawn request: requester 2 comes and goes while requester 0 is in flight.
    begin : withdrawn
      clear_stats();
      set_req(0, 1'b1, 18'd11, 18'd13);
      for (int k = 0; k < 10 && req_ready[0] !== 1'b1; k++) step();
      req_valid[0] = 1'b0;
      for (int k = 0; k < 6; k++) step();
      set_req(2, 1'b1, 18'd5, 18'd5);
      for (int k = 0; k < 3; k++) step();
      req_valid[2] = 1'b0;
      for (int k = 0; k < 40 && resp_cnt == 0; k++) step();
      for (int k = 0; k < 5; k++) step();
      check("wd_ready_bits", rdy_or, 4'b0001);
      check("wd_resp_bits", resp_or, 4'b0001);
      check("wd_prod", last_resp_p, 36'd143);
      check("wd_counts", rdy_cnt * 10 + resp_cnt, 11);
    end

    // Stuck multiplier: busy never rises; err is flagged and stays set.
    check("err_before_stuck", err, 0);
    stuck = 1'b1;
    do_op(1, 18'd3, 18'd5, STUCK_P, 6, "stuck", t0);
    check("stuck_err_cycle", err_cyc - t0, 5);
    stuck = 1'b0; busy_cnt = 0;
    do_op(2, 18'd6, 18'd7, 36'd42, 19, "after_stuck", t0);
    check("err_sticky", err, 1);

    // Reset in the middle of an operation with the multiplier busy.
    begin : reset_mid
      clear_stats();
      set_req(3, 1'b1, 18'd100, 18'd100);
      for (int k = 0; k < 10 && req_ready[3] !== 1'b1; k++) step();
      req_valid[3] = 1'b0;
      for (int k = 0; k < 5; k++) step();
      check("mid_busy_high", mul_busy, 1);
      reset = 1'b1;
      #1;
      check("mid_rst_p", resp_p, 0);
      check("mid_rst_ab", {mul_a, mul_b}, 0);
      check("mid_rst_ctl", {req_ready, resp_valid, mul_start, err}, 0);
      step(); step();
      reset = 1'b0;
      err_cyc = -1;
      clear_stats();
      set_req(1, 1'b1, 18'd7, 18'h3FFF7);
      for (int k = 0; k < 60 && req_ready[1] !== 1'b1; k++) step();
      req_valid[1] = 1'b0;
      check("mid_drain_hold", last_rdy_cyc - fall_cyc, 2);
      for (int k = 0; k < 60 && resp_cnt == 0; k++) step();
      for (int k = 0; k < 3; k++) step();
      check("mid_new_prod", last_resp_p, 36'hFFFFFFFC1);
      check("mid_new_owner", last_resp, 4'b0010);
      check("mid_resp_count", resp_cnt, 1);
      check("mid_err_clear", err, 0);
    end

    // Random traffic against the reference model, starting from a fresh reset.
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step(); step(); step();
    lat_lo = 1; lat_hi = 6;
    m_free = 1'b1; m_ptr = 0; model_on = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      step();
      for (int i = 0; i < N; i++) begin
        if (req_ready[i]) begin
          // Operands may change freely once accepted.
          set_req(i, 1'b0, 18'($urandom()), 18'($urandom()));
        end else if (req_valid[i]) begin
          if ($urandom_range(15, 0) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(2, 0) == 0) begin
          if ($urandom_range(7, 0) == 0) set_req(i, 1'b1, 18'h20000, 18'h1FFFF);
          else set_req(i, 1'b1, 18'($urandom()), 18'($urandom()));
        end
      end
    end
    req_valid = '0;
    for (int k = 0; k < 40; k++) step();
    model_on = 1'b0;
    check("rand_idle_at_end", m_free, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
